// File: rtl/l2_rr_arbiter.sv
// rtl/l2_rr_arbiter.sv - round-robin arbiter sharing one L2 port among NUM_PORTS requesters
module l2_rr_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  localparam int IDW = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_read,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             req_resp,
  output logic [DATA_WIDTH-1:0]            req_rdata,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic                             mem_resp,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic [IDW-1:0]                   grant_id,
  output logic                             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [IDW:0]   NP   = (IDW+1)'(NUM_PORTS);
  localparam logic [IDW-1:0] LAST = IDW'(NUM_PORTS - 1);

  logic [1:0]            state;
  logic [IDW-1:0]        ptr;
  logic                  op_write;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [NUM_PORTS-1:0]  pending;
  logic                  found;
  logic [IDW-1:0]        winner;
  logic [IDW:0]          sum;
  logic [IDW-1:0]        idx;

  assign pending = req_read | req_write;

  // Scan ptr, ptr+1, ... modulo NUM_PORTS; first pending port wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= NP) sum = sum - NP;
      idx = sum[IDW-1:0];
      if (!found && pending[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_id    <= '0;
      op_write    <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      rdata_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_id    <= winner;
            op_write    <= req_write[winner];
            mem_address <= req_address[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata   <= req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (mem_resp) begin
            if (!op_write) rdata_q <= mem_rdata;
            state <= RESP;
          end
        end
        RESP: begin
          ptr   <= (grant_id == LAST) ? '0 : grant_id + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_resp = '0;
    if (state == RESP) req_resp[grant_id] = 1'b1;
  end

  assign req_rdata = rdata_q;
  assign mem_read  = (state == GRANT) && !op_write;
  assign mem_write = (state == GRANT) && op_write;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_l2_rr_arbiter.sv
// tb/tb_l2_rr_arbiter.sv - randomized self-checking bench for l2_rr_arbiter
module tb_l2_rr_arbiter;

  localparam int N   = 4;
  localparam int AW  = 16;
  localparam int DW  = 128;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_read, req_write, req_resp;
  logic [N*AW-1:0]   req_address;
  logic [N*DW-1:0]   req_wdata;
  logic [DW-1:0]     req_rdata, mem_wdata, mem_rdata;
  logic              mem_read, mem_write, mem_resp, busy;
  logic [AW-1:0]     mem_address;
  logic [IDW-1:0]    grant_id;

  logic              rd [N];
  logic              wr [N];
  logic [AW-1:0]     ad [N];
  logic [DW-1:0]     wd [N];

  int                checks = 0;
  int                failures = 0;
  int                m_ptr;
  logic [DW-1:0]     m_rdata;

  l2_rr_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata),
    .req_resp(req_resp), .req_rdata(req_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_read[i]               = rd[i];
      req_write[i]              = wr[i];
      req_address[i*AW +: AW]   = ad[i];
      req_wdata[i*DW +: DW]     = wd[i];
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic clear_reqs;
    for (int i = 0; i < N; i++) begin
      rd[i] = 1'b0;
      wr[i] = 1'b0;
    end
  endtask

  // Called in IDLE with at least one pending port; runs one transaction and leaves the DUT in IDLE.
  task automatic run_txn(input int delay, input logic [DW-1:0] rdat, input bit mutate,
                         input bit drop, output int w);
    logic          op;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    logic [N-1:0]  onehot;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int p;
      p = (m_ptr + k) % N;
      if (w < 0 && (rd[p] || wr[p])) w = p;
    end
    op  = wr[w];
    ea  = ad[w];
    ewd = wd[w];
    tick;
    check("grant_id", grant_id, w);
    check("mem_read", mem_read, !op);
    check("mem_write", mem_write, op);
    check("mem_address", mem_address, ea);
    check("mem_wdata", mem_wdata, ewd);
    check("busy_grant", busy, 1'b1);
    if (mutate) begin
      ad[w] = AW'($urandom());
      wd[w] = rand_line();
    end
    if (drop) begin
      rd[w] = 1'b0;
      wr[w] = 1'b0;
    end
    for (int i = 1; i < delay; i++) begin
      tick;
      check("hold_strobe", {mem_read, mem_write}, op ? 2'b01 : 2'b10);
      check("hold_addr", mem_address, ea);
      check("hold_resp", req_resp, 0);
    end
    mem_rdata = rdat;
    mem_resp  = 1'b1;
    tick;
    mem_resp  = ($urandom_range(0, 3) == 0);
    mem_rdata = rand_line();
    if (!op) m_rdata = rdat;
    onehot = N'(1) << w;
    check("req_resp", req_resp, onehot);
    check("req_rdata", req_rdata, m_rdata);
    check("resp_strobes", {mem_read, mem_write}, 2'b00);
    check("resp_addr", mem_address, ea);
    rd[w] = 1'b0;
    wr[w] = 1'b0;
    m_ptr = (w + 1) % N;
    tick;
    mem_resp = 1'b0;
    check("idle_busy", busy, 1'b0);
    check("idle_resp", req_resp, 0);
  endtask

  int w;

  initial begin
    rst = 1'b1;
    mem_resp = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < N; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; wd[i] = '0;
    end
    m_ptr = 0;
    m_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_grant_id", grant_id, 0);
    check("rst_strobes", {mem_read, mem_write}, 2'b00);
    check("rst_req_resp", req_resp, 0);
    check("rst_rdata", req_rdata, 0);
    rst = 1'b0;
    tick;

    // single read, port 2
    rd[2] = 1'b1; ad[2] = 16'h1A40;
    run_txn(3, {32'hDEADDEAD, 64'h0123_4567_89AB_CDEF, 32'hBEEFBEEF}, 1'b0, 1'b0, w);

    // write, port 1; read data must not change
    wr[1] = 1'b1; ad[1] = 16'h0200; wd[1] = {16{8'h55}};
    run_txn(2, rand_line(), 1'b0, 1'b0, w);

    // async reset mid-GRANT
    rd[0] = 1'b1; ad[0] = 16'h0ABC; wd[0] = rand_line();
    tick;
    check("pre_rst_read", mem_read, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_read", mem_read, 1'b0);
    check("arst_addr", mem_address, 0);
    check("arst_wdata", mem_wdata, 0);
    check("arst_rdata", req_rdata, 0);
    check("arst_grant", grant_id, 0);
    clear_reqs();
    tick;
    rst = 1'b0;
    m_ptr = 0;
    m_rdata = '0;
    mem_resp = 1'b1;
    mem_rdata = rand_line();
    tick;
    mem_resp = 1'b0;
    check("post_rst_resp", req_resp, 0);
    tick;
    check("post_rst_resp2", req_resp, 0);
    check("post_rst_busy", busy, 1'b0);

    // continuous requests from all ports, immediate mem_resp
    for (int i = 0; i < N; i++) begin
      rd[i] = 1'b1; ad[i] = AW'(16'h0100 * (i + 1)); wd[i] = rand_line();
    end
    for (int t = 0; t < 5; t++) begin
      run_txn(1, rand_line(), 1'b0, 1'b0, w);
      check("rr_order", w, t % N);
      rd[w] = 1'b1;
    end

    // ptr is 1 here; only ports 0 and 3 pending
    clear_reqs();
    rd[0] = 1'b1; wr[3] = 1'b1; wd[3] = rand_line();
    run_txn(1, rand_line(), 1'b0, 1'b0, w);
    check("skip_first", w, 3);
    run_txn(1, rand_line(), 1'b0, 1'b0, w);
    check("skip_second", w, 0);

    // payload latching with request dropped during GRANT
    rd[0] = 1'b1; ad[0] = 16'h0010;
    run_txn(2, rand_line(), 1'b1, 1'b1, w);

    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      bit any;
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!rd[i] && !wr[i] && $urandom_range(0, 9) < 4) begin
          int mode;
          mode  = $urandom_range(0, 9);
          rd[i] = (mode == 0) || (mode > 4);
          wr[i] = (mode <= 4);
          ad[i] = AW'($urandom());
          wd[i] = rand_line();
        end
        if (rd[i] || wr[i]) any = 1'b1;
      end
      if (any) begin
        run_txn($urandom_range(1, 4), rand_line(), bit'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0), w);
      end else begin
        mem_resp = bit'($urandom_range(0, 1));
        tick;
        mem_resp = 1'b0;
        check("stray_busy", busy, 1'b0);
        check("stray_resp", req_resp, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
